// File: rtl/top_fpga.sv
// Pattern capture / replay / PRBS-15 stream generator with a consecutive-pattern detector.
// Captures four bytes after reset, replays them N times, then emits PRBS-15 bytes.

module pattern_det (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  data_in,
    input  logic [31:0] pattern,
    input  logic [7:0]  n_target,
    output logic        found
);
    logic [1:0] pattern_counter;
    logic [7:0] repeats;
    logic [7:0] exp_byte;
    logic [7:0] rep_inc;
    logic       match;

    // Expected byte for the current position, and saturating repeat increment
    always_comb begin
        exp_byte = 8'h00;
        case (pattern_counter)
            2'd0:    exp_byte = pattern[31:24];
            2'd1:    exp_byte = pattern[23:16];
            2'd2:    exp_byte = pattern[15:8];
            default: exp_byte = pattern[7:0];
        endcase
        match   = (data_in == exp_byte);
        rep_inc = (repeats == 8'hFF) ? 8'hFF : repeats + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_counter <= 2'd0;
            repeats         <= 8'd0;
            found           <= 1'b0;
        end else if (en) begin
            if (match) begin
                pattern_counter <= pattern_counter + 2'd1;
                if (pattern_counter == 2'd3) begin
                    repeats <= rep_inc;
                    if ((rep_inc == n_target) && (n_target != 8'd0))
                        found <= 1'b1;
                end
            end else begin
                repeats         <= 8'd0;
                // A mismatching byte may itself start a new pattern instance
                pattern_counter <= (data_in == pattern[31:24]) ? 2'd1 : 2'd0;
            end
        end
    end
endmodule

module top_fpga (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pattern_in,
    input  logic [7:0] n_repeats,
    output logic       pattern_found,
    output logic [7:0] prbs_out
);
    typedef enum logic [1:0] {CAPTURE, REPEAT, PRBS} phase_t;

    phase_t      phase, phase_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [7:0]  pass_cnt, pass_cnt_nxt;
    logic [7:0]  pass_inc;
    logic [7:0]  n_lat;
    logic [31:0] data_parallel;
    logic [14:0] lfsr;
    logic [14:0] lfsr_adv;
    logic [14:0] seed;
    logic [7:0]  rep_byte;
    logic        finsh;
    logic        det_en;

    // Eight PRBS-15 steps per byte; the new bits land in [7:0], oldest in bit 7
    function automatic logic [14:0] lfsr_step8(input logic [14:0] s);
        logic [14:0] v;
        v = s;
        for (int i = 0; i < 8; i++)
            v = {v[13:0], v[14] ^ v[13]};
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            phase    <= CAPTURE;
            byte_idx <= 2'd0;
            pass_cnt <= 8'd0;
        end else begin
            phase    <= phase_nxt;
            byte_idx <= byte_idx_nxt;
            pass_cnt <= pass_cnt_nxt;
        end
    end

    // Phase sequencing: 4 capture edges, 4*N replay edges, then PRBS forever
    always_comb begin
        phase_nxt    = phase;
        byte_idx_nxt = byte_idx;
        pass_cnt_nxt = pass_cnt;
        pass_inc     = pass_cnt + 8'd1;
        case (phase)
            CAPTURE: begin
                byte_idx_nxt = byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    pass_cnt_nxt = 8'd0;
                    phase_nxt    = (n_repeats == 8'd0) ? PRBS : REPEAT;
                end
            end
            REPEAT: begin
                byte_idx_nxt = byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    pass_cnt_nxt = pass_inc;
                    if (pass_inc == n_lat)
                        phase_nxt = PRBS;
                end
            end
            PRBS:    phase_nxt = PRBS;
            default: phase_nxt = CAPTURE;
        endcase
    end

    // Seed uses the fully captured word, including the byte arriving this edge
    always_comb begin
        seed     = {data_parallel[6:0], pattern_in};
        if (seed == 15'd0)
            seed = 15'h7FFF;
        lfsr_adv = lfsr_step8(lfsr);
        rep_byte = 8'h00;
        case (byte_idx)
            2'd0:    rep_byte = data_parallel[31:24];
            2'd1:    rep_byte = data_parallel[23:16];
            2'd2:    rep_byte = data_parallel[15:8];
            default: rep_byte = data_parallel[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data_parallel <= 32'd0;
            n_lat         <= 8'd0;
            lfsr          <= 15'd0;
            prbs_out      <= 8'd0;
            finsh         <= 1'b0;
            det_en        <= 1'b0;
        end else begin
            det_en <= (phase != CAPTURE);
            case (phase)
                CAPTURE: begin
                    data_parallel <= {data_parallel[23:0], pattern_in};
                    if (byte_idx == 2'd3) begin
                        n_lat <= n_repeats;
                        lfsr  <= seed;
                    end
                end
                REPEAT:  prbs_out <= rep_byte;
                PRBS: begin
                    lfsr     <= lfsr_adv;
                    prbs_out <= lfsr_adv[7:0];
                    finsh    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    pattern_det pattern_det_inst (
        .clk      (clk),
        .rst      (rst_n),
        .en       (det_en),
        .data_in  (prbs_out),
        .pattern  (data_parallel),
        .n_target (n_lat),
        .found    (pattern_found)
    );
endmodule

// File: tb/tb_top_fpga.sv
// Self-checking bench for top_fpga: edge-indexed stream model plus hand-computed pins.

module tb_top_fpga;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic [7:0] n_repeats = 8'h00;
    logic       pattern_found;
    logic [7:0] prbs_out;

    always #5 clk = ~clk;

    top_fpga dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pattern_in    (pattern_in),
        .n_repeats     (n_repeats),
        .pattern_found (pattern_found),
        .prbs_out      (prbs_out)
    );

    int         checks = 0;
    int         failures = 0;
    int         k = -1;
    bit         model_on = 1'b0;
    logic [7:0] pat [4];
    int         n_m = 0;
    logic [7:0] exp_prbs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=E%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    // PRBS reference as a bit sequence: b[t] = b[t-15] ^ b[t-14], seed bits oldest first
    task automatic build_prbs(input int nbytes);
        logic [14:0] sd;
        logic [7:0]  v;
        bit          hist [$];
        bit          nb;
        int          t;
        sd = {pat[2][6:0], pat[3]};
        if (sd == 15'd0) sd = 15'h7FFF;
        exp_prbs.delete();
        for (int i = 14; i >= 0; i--) hist.push_back(sd[i]);
        for (int b = 0; b < nbytes; b++) begin
            v = 8'h00;
            for (int j = 0; j < 8; j++) begin
                t  = hist.size();
                nb = hist[t-15] ^ hist[t-14];
                hist.push_back(nb);
                v = {v[6:0], nb};
            end
            exp_prbs.push_back(v);
        end
    endtask

    // Expected outputs follow directly from the edge number since reset release
    always @(negedge clk) begin
        logic [7:0] e;
        int         rep_end;
        if (model_on && k >= 0) begin
            rep_end = 4 + 4 * n_m;
            if (k < 4)            e = 8'h00;
            else if (k < rep_end) e = pat[(k - 4) % 4];
            else                  e = exp_prbs[k - rep_end];
            check("prbs_out", 32'(prbs_out), 32'(e));
            check("finsh", 32'(dut.finsh), 32'(k >= rep_end));
            check("pattern_found", 32'(pattern_found), 32'((n_m != 0) && (k >= rep_end)));
            if (k >= 3)
                check("data_parallel", dut.data_parallel, {pat[0], pat[1], pat[2], pat[3]});
            if (n_m != 0 && k >= 5 && k <= rep_end) begin
                check("pattern_counter", 32'(dut.pattern_det_inst.pattern_counter), 32'((k - 4) % 4));
                check("repeats", 32'(dut.pattern_det_inst.repeats), 32'((k - 4) / 4));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic start(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3, input int n);
        model_on  = 1'b0;
        rst_n     = 1'b1;
        pat       = '{p0, p1, p2, p3};
        n_m       = n;
        n_repeats = 8'(n);
        build_prbs(64);
        @(negedge clk);
        #2;
        check("rst_prbs_out", 32'(prbs_out), 32'h0);
        check("rst_found", 32'(pattern_found), 32'h0);
        check("rst_finsh", 32'(dut.finsh), 32'h0);
        check("rst_data_parallel", dut.data_parallel, 32'h0);
        check("rst_counter", 32'(dut.pattern_det_inst.pattern_counter), 32'h0);
        check("rst_repeats", 32'(dut.pattern_det_inst.repeats), 32'h0);
        pattern_in = p0;
        k          = -1;
        rst_n      = 1'b0;
        model_on   = 1'b1;
    endtask

    // Advance to edge E<upto>; after capture pattern_in carries junk that must be ignored
    task automatic run_to(input int upto);
        while (k < upto) begin
            tick();
            if (k + 1 < 4) pattern_in = pat[k + 1];
            else           pattern_in = 8'(k * 37 + 5);
        end
    endtask

    logic [7:0] late [4];

    initial begin
        #1 rst_n = 1'b1;

        // Scenario 1: AB CD EF 58, N=3; seed 0x6F58 gives 63, D1 first
        start(8'hAB, 8'hCD, 8'hEF, 8'h58, 3);
        run_to(4);
        check("s1_first_byte", 32'(prbs_out), 32'hAB);
        run_to(15);
        check("s1_last_rep", 32'(prbs_out), 32'h58);
        check("s1_found_early", 32'(pattern_found), 32'h0);
        run_to(16);
        check("s1_prbs0", 32'(prbs_out), 32'h63);
        check("s1_found", 32'(pattern_found), 32'h1);
        run_to(17);
        check("s1_prbs1", 32'(prbs_out), 32'hD1);
        run_to(24);

        // Scenario 2: FA E1 89 EE, N=5
        start(8'hFA, 8'hE1, 8'h89, 8'hEE, 5);
        run_to(23);
        check("s2_found_early", 32'(pattern_found), 32'h0);
        run_to(24);
        check("s2_found", 32'(pattern_found), 32'h1);
        run_to(28);

        // Scenario 3: new inputs without reset are ignored
        late = '{8'h35, 8'hFE, 8'h88, 8'h12};
        n_repeats = 8'd7;
        for (int i = 0; i < 4; i++) begin
            pattern_in = late[i];
            tick();
        end
        run_to(40);
        check("s3_data_parallel", dut.data_parallel, 32'hFAE189EE);
        check("s3_found", 32'(pattern_found), 32'h1);

        // Scenario 4: reset mid-replay clears outputs asynchronously
        start(8'hA5, 8'h5A, 8'hC3, 8'h3C, 4);
        run_to(7);
        model_on = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("abort_prbs_out", 32'(prbs_out), 32'h0);
        check("abort_found", 32'(pattern_found), 32'h0);
        check("abort_finsh", 32'(dut.finsh), 32'h0);
        check("abort_data_parallel", dut.data_parallel, 32'h0);

        // Scenario 5: detector progress with 11 22 33 44, N=2
        start(8'h11, 8'h22, 8'h33, 8'h44, 2);
        run_to(11);
        check("det_repeats_e11", 32'(dut.pattern_det_inst.repeats), 32'h1);
        check("det_counter_e11", 32'(dut.pattern_det_inst.pattern_counter), 32'h3);
        run_to(12);
        check("det_repeats_e12", 32'(dut.pattern_det_inst.repeats), 32'h2);
        check("det_found_e12", 32'(pattern_found), 32'h1);
        run_to(20);

        // Scenario 6: zero pattern, N=0; all-ones seed yields 00 02 00 0C
        start(8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_to(4);
        check("z_prbs0", 32'(prbs_out), 32'h00);
        check("z_finsh", 32'(dut.finsh), 32'h1);
        run_to(5);
        check("z_prbs1", 32'(prbs_out), 32'h02);
        run_to(7);
        check("z_prbs3", 32'(prbs_out), 32'h0C);
        run_to(30);
        check("z_found", 32'(pattern_found), 32'h0);

        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/top_fpga.md
Name: top_fpga

Overview:
- Top-level FPGA block that loads a 4-byte pattern from an 8-bit input after reset.
- It replays that pattern a programmable number of times on a byte stream, then switches the stream to a PRBS-15 sequence.
- An internal pattern detector watches the stream and flags once the pattern has been seen the programmed number of times, consecutively.
- Internal sub-blocks: capture register (data_parallel), generator (drives prbs_out and a done flag finsh), and pattern_det_inst (holds pattern_counter and repeats).

Parameters:
- None. Byte width 8, pattern length 4 bytes and PRBS-15 polynomial are fixed.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset. Asynchronous, active-high: rst_n=1 holds the block in reset; rst_n=0 is normal operation.
- pattern_in  input  8  pattern byte, sampled during the capture phase.
- n_repeats  input  8  number of pattern repetitions to generate and to detect.
- pattern_found  output  1  sticky flag: the pattern was detected n_repeats times consecutively.
- prbs_out  output  8  registered output byte stream.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - prbs_out=0, pattern_found=0, finsh=0, data_parallel=0.
  - pattern_counter=0, repeats=0, phase=CAPTURE, byte index=0.
- Edges are numbered E0, E1, ... starting with the first rising edge at which rst_n=0.
- CAPTURE phase (E0..E3):
  - data_parallel <= {data_parallel[23:0], pattern_in}, so the byte sampled at E0 ends in bits [31:24] (byte0).
  - n_repeats is latched as N at E3.
  - prbs_out stays 0.
- REPEAT phase (E4..E(3+4N)):
  - prbs_out <= byte[(k-4) mod 4] at edge Ek, bytes in order byte0..byte3, repeated N times.
  - At E3 the LFSR is seeded with data_parallel[14:0]; an all-zero seed is replaced by 15'h7FFF.
- PRBS phase (from E(4+4N) onward):
  - finsh <= 1 and stays 1 until reset.
  - Each edge the LFSR advances 8 steps. One step: nb = s[14]^s[13]; s <= {s[13:0], nb}.
  - prbs_out <= the 8 new bits, first-generated bit in the MSB.
- N=0: REPEAT phase is skipped. finsh rises at E4, prbs_out carries PRBS from E4, and pattern_found never asserts.
- Detector:
  - Operates from E5 onward and samples the registered prbs_out each edge.
  - pattern_counter (0..3) indexes the expected byte of data_parallel.
  - Match: pattern_counter increments. On a match at index 3, it wraps to 0 and repeats increments (saturating at 255).
  - Mismatch: repeats <= 0. pattern_counter <= 1 if the byte equals byte0, else 0.
  - When the increment of repeats makes it equal N (N≠0), pattern_found <= 1 at that same edge. It is sticky until reset.
  - For N≥1 with no corruption, pattern_found rises at E(4+4N), the same edge that finsh rises.
- Changes to pattern_in or n_repeats after E3 are ignored until the next reset.
- Reset mid-operation aborts immediately and returns to CAPTURE. The next pattern and N are taken fresh.
- Outputs are glitch-free registers. No combinational path from inputs to outputs.

Test Plan:
- Capture AB,CD,EF,58 with n_repeats=3, from reset release:
  - prbs_out = AB CD EF 58 ×3 at E4..E15.
  - finsh and pattern_found rise at E16; PRBS bytes follow (seed 0x6F58 & 0x7FFF).
- Re-apply reset, then capture FA,E1,89,EE with n_repeats=5:
  - 20 pattern bytes appear.
  - pattern_found=0 until E24, then 1 and stays 1.
- After the previous scenario, without reset, set n_repeats=7 and drive 35,FE,88,12:
  - data_parallel stays FAE189EE, prbs_out stays on PRBS, pattern_found stays 1.
- Assert reset in the middle of the REPEAT phase:
  - All outputs drop to 0 immediately (asynchronously).
  - After release, the new capture replays correctly.
- n_repeats=0, pattern 00,00,00,00:
  - Seed is forced to 7FFF; the PRBS sequence is nonzero from E4.
  - finsh=1 at E4; pattern_found never asserts.
- Detector check: with pattern 11,22,33,44 and N=2, the REPEAT phase yields pattern_counter cycling 1,2,3,0 and repeats reaching 2 exactly at E12.
